// File: rtl/iir_coeff_ctrl.sv
// Coefficient swap controller for an IIR filter.
// Coefficients are written into a shadow set at any time. A commit drains
// the samples still in the filter, copies the shadow set into the active set,
// then holds the filter in reset so that no stale state mixes with the new
// coefficients.
module iir_coeff_ctrl #(
  parameter int unsigned NB           = 12,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned FLUSH_CYC    = 2,
  parameter int unsigned DRAIN_TO     = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_addr,
  input  logic [NB-1:0]   cfg_data,
  input  logic            cfg_commit,
  input  logic            s_valid,
  input  logic [NB-1:0]   s_data,
  output logic            s_ready,
  output logic            f_vIn,
  output logic [NB-1:0]   f_dIn,
  output logic [3*NB-1:0] f_b,
  output logic [2*NB-1:0] f_a,
  output logic            f_rst_n,
  input  logic            f_vOut,
  output logic            busy,
  output logic            swap_done,
  output logic            drain_err,
  output logic            commit_err
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned TW = $clog2(DRAIN_TO) + 1;
  localparam int unsigned FW = $clog2(FLUSH_CYC) + 1;

  localparam logic [IW-1:0] MaxInfl   = IW'(MAX_INFLIGHT);
  localparam logic [TW-1:0] TimerLast = TW'(DRAIN_TO - 1);
  localparam logic [FW-1:0] FlushLast = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {StRun, StDrain, StSwap, StFlush} state_e;

  state_e                 state_q, state_d;
  logic [4:0][NB-1:0]     shadow_q, shadow_d;
  logic [4:0][NB-1:0]     active_q, active_d;
  logic [IW-1:0]          inflight_q, inflight_d, inflight_nxt;
  logic [TW-1:0]          timer_q, timer_d;
  logic [FW-1:0]          flush_q, flush_d;
  logic                   f_vin_q, f_vin_d;
  logic [NB-1:0]          f_din_q, f_din_d;
  logic                   swap_done_q, swap_done_d;
  logic                   accept;

  assign s_ready = !rst && (state_q == StRun) && (inflight_q < MaxInfl);
  assign accept  = s_valid && s_ready;
  assign busy    = !rst && (state_q != StRun);
  assign f_rst_n = !rst && (state_q != StFlush);
  assign f_vIn     = f_vin_q;
  assign f_dIn     = f_din_q;
  assign swap_done = swap_done_q;
  assign f_b = {active_q[2], active_q[1], active_q[0]};
  assign f_a = {active_q[4], active_q[3]};

  // Occupancy after this cycle's accept and return, saturating at zero.
  always_comb begin
    inflight_nxt = inflight_q;
    if (accept && !f_vOut) begin
      inflight_nxt = inflight_q + 1'b1;
    end else if (!accept && f_vOut && (inflight_q != '0)) begin
      inflight_nxt = inflight_q - 1'b1;
    end
  end

  // Next-state, shadow/active updates and pulse outputs.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    inflight_d  = inflight_nxt;
    timer_d     = '0;
    flush_d     = '0;
    f_vin_d     = accept;
    f_din_d     = accept ? s_data : f_din_q;
    swap_done_d = 1'b0;
    drain_err   = 1'b0;
    commit_err  = 1'b0;

    if (cfg_we) begin
      case (cfg_addr)
        3'd0:    shadow_d[0] = cfg_data;
        3'd1:    shadow_d[1] = cfg_data;
        3'd2:    shadow_d[2] = cfg_data;
        3'd3:    shadow_d[3] = cfg_data;
        3'd4:    shadow_d[4] = cfg_data;
        default: ;
      endcase
    end

    unique case (state_q)
      StRun: begin
        if (cfg_commit) state_d = StDrain;
      end
      StDrain: begin
        commit_err = cfg_commit;
        timer_d    = timer_q + 1'b1;
        // Use the post-return count so the swap follows the last return directly.
        if (inflight_nxt == '0) begin
          state_d = StSwap;
        end else if (timer_q == TimerLast) begin
          state_d   = StSwap;
          drain_err = 1'b1;
        end
      end
      StSwap: begin
        commit_err = cfg_commit;
        // shadow_q predates any write in this cycle.
        active_d   = shadow_q;
        state_d    = StFlush;
      end
      StFlush: begin
        commit_err = cfg_commit;
        inflight_d = '0;
        flush_d    = flush_q + 1'b1;
        if (flush_q == FlushLast) begin
          state_d     = StRun;
          swap_done_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    if (rst) begin
      drain_err  = 1'b0;
      commit_err = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      shadow_q    <= '0;
      active_q    <= '0;
      inflight_q  <= '0;
      timer_q     <= '0;
      flush_q     <= '0;
      f_vin_q     <= 1'b0;
      f_din_q     <= '0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      inflight_q  <= inflight_d;
      timer_q     <= timer_d;
      flush_q     <= flush_d;
      f_vin_q     <= f_vin_d;
      f_din_q     <= f_din_d;
      swap_done_q <= swap_done_d;
    end
  end

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Self-checking bench for iir_coeff_ctrl: scoreboard on the sample path plus
// cycle-indexed checks of the swap sequence.
module tb_iir_coeff_ctrl;

  localparam int NB = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [2:0]      cfg_addr;
  logic [NB-1:0]   cfg_data;
  logic            cfg_commit;
  logic            s_valid;
  logic [NB-1:0]   s_data;
  logic            s_ready;
  logic            f_vIn;
  logic [NB-1:0]   f_dIn;
  logic [3*NB-1:0] f_b;
  logic [2*NB-1:0] f_a;
  logic            f_rst_n;
  logic            f_vOut;
  logic            busy;
  logic            swap_done;
  logic            drain_err;
  logic            commit_err;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int swap_cnt = 0;
  int derr_cnt = 0;
  logic [NB-1:0] exp_q[$];

  always #5 clk = ~clk;

  iir_coeff_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .f_vIn      (f_vIn),
    .f_dIn      (f_dIn),
    .f_b        (f_b),
    .f_a        (f_a),
    .f_rst_n    (f_rst_n),
    .f_vOut     (f_vOut),
    .busy       (busy),
    .swap_done  (swap_done),
    .drain_err  (drain_err),
    .commit_err (commit_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted samples must reappear on f_dIn one cycle later, in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (f_vIn) begin
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_eq("sb_data", 64'(f_dIn), 64'(exp_q.pop_front()));
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        acc_cnt++;
      end
      if (swap_done) swap_cnt++;
      if (drain_err) derr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    s_valid = 1'b0; s_data = '0; f_vOut = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [2:0] addr, input logic [NB-1:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic push_samples(input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = NB'($urandom);
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int base, sbase, dbase, first_low, derr_at, swap_at;

    // Reset state
    idle_inputs();
    rst = 1'b1;
    tick();
    #1;
    check_eq("rst_f_rst_n", 64'(f_rst_n), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_s_ready", 64'(s_ready), 64'd0);
    check_eq("rst_f_b", 64'(f_b), 64'd0);
    check_eq("rst_f_a", 64'(f_a), 64'd0);
    check_eq("rst_f_vIn", 64'(f_vIn), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("run_s_ready", 64'(s_ready), 64'd1);
    check_eq("run_f_rst_n", 64'(f_rst_n), 64'd1);
    tick();

    // Idle commit: DRAIN 1, SWAP 1, FLUSH 2, swap_done 5 cycles after commit
    do_reset();
    write_cfg(3'd0, 12'h100);
    write_cfg(3'd1, 12'h200);
    write_cfg(3'd2, 12'h100);
    write_cfg(3'd3, 12'hF00);
    write_cfg(3'd4, 12'h080);
    write_cfg(3'd6, 12'hABC);
    commit();
    for (int i = 1; i <= 7; i++) begin
      #1;
      check_eq($sformatf("idle_f_rst_n_c%0d", i), 64'(f_rst_n), 64'(!(i == 3 || i == 4)));
      check_eq($sformatf("idle_busy_c%0d", i), 64'(busy), 64'(i <= 4));
      check_eq($sformatf("idle_swap_done_c%0d", i), 64'(swap_done), 64'(i == 5));
      tick();
    end
    check_eq("idle_f_b", 64'(f_b), 64'h100200100);
    check_eq("idle_f_a", 64'(f_a), 64'h080F00);

    // Backpressure at MAX_INFLIGHT
    do_reset();
    base = acc_cnt;
    push_samples(12);
    s_valid = 1'b1;
    #1;
    check_eq("full_accepts", 64'(acc_cnt - base), 64'd8);
    check_eq("full_s_ready", 64'(s_ready), 64'd0);
    f_vOut = 1'b1;
    tick();
    f_vOut = 1'b0;
    push_samples(5);
    s_valid = 1'b1;
    #1;
    check_eq("one_more_accepts", 64'(acc_cnt - base), 64'd9);
    check_eq("one_more_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    tick();

    // Drain with 3 in flight, returns at +4, +6, +9
    do_reset();
    push_samples(3);
    dbase = derr_cnt;
    sbase = swap_cnt;
    commit();
    first_low = -1;
    swap_at = -1;
    for (int i = 1; i <= 15; i++) begin
      f_vOut = (i == 4 || i == 6 || i == 9);
      #1;
      if (i <= 12) check_eq($sformatf("drain3_s_ready_c%0d", i), 64'(s_ready), 64'd0);
      if (!f_rst_n && first_low < 0) first_low = i;
      if (swap_done && swap_at < 0) swap_at = i;
      tick();
    end
    f_vOut = 1'b0;
    check_eq("drain3_flush_start", 64'(first_low), 64'd11);
    check_eq("drain3_swap_done_at", 64'(swap_at), 64'd13);
    check_eq("drain3_no_drain_err", 64'(derr_cnt - dbase), 64'd0);
    check_eq("drain3_swaps", 64'(swap_cnt - sbase), 64'd1);

    // Drain timeout
    do_reset();
    push_samples(1);
    dbase = derr_cnt;
    commit();
    first_low = -1;
    swap_at = -1;
    derr_at = -1;
    for (int i = 1; i <= 70; i++) begin
      #1;
      if (drain_err && derr_at < 0) derr_at = i;
      if (!f_rst_n && first_low < 0) first_low = i;
      if (swap_done && swap_at < 0) swap_at = i;
      tick();
    end
    check_eq("to_drain_err_at", 64'(derr_at), 64'd64);
    check_eq("to_drain_err_cnt", 64'(derr_cnt - dbase), 64'd1);
    check_eq("to_flush_start", 64'(first_low), 64'd66);
    check_eq("to_swap_done_at", 64'(swap_at), 64'd68);
    base = acc_cnt;
    push_samples(12);
    check_eq("to_inflight_cleared", 64'(acc_cnt - base), 64'd8);

    // Commit during FLUSH is rejected; write during SWAP lands in shadow only
    do_reset();
    write_cfg(3'd0, 12'h123);
    sbase = swap_cnt;
    commit();
    for (int i = 1; i <= 10; i++) begin
      cfg_we     = (i == 2);
      cfg_addr   = 3'd0;
      cfg_data   = 12'h7FF;
      cfg_commit = (i == 3);
      #1;
      check_eq($sformatf("cerr_c%0d", i), 64'(commit_err), 64'(i == 3));
      tick();
    end
    idle_inputs();
    check_eq("cerr_swaps", 64'(swap_cnt - sbase), 64'd1);
    check_eq("cerr_active_b0", 64'(f_b[NB-1:0]), 64'h123);
    check_eq("cerr_busy", 64'(busy), 64'd0);
    commit();
    for (int i = 1; i <= 6; i++) tick();
    check_eq("cerr_shadow_b0", 64'(f_b[NB-1:0]), 64'h7FF);

    // Reset during DRAIN aborts the swap
    do_reset();
    write_cfg(3'd0, 12'h055);
    write_cfg(3'd4, 12'h0AA);
    push_samples(1);
    sbase = swap_cnt;
    commit();
    tick();
    rst = 1'b1;
    #1;
    check_eq("abort_rst_f_rst_n", 64'(f_rst_n), 64'd0);
    check_eq("abort_rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_f_rst_n", 64'(f_rst_n), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      check_eq($sformatf("abort_f_rst_n_c%0d", i), 64'(f_rst_n), 64'd1);
      tick();
    end
    check_eq("abort_no_swap", 64'(swap_cnt - sbase), 64'd0);
    check_eq("abort_f_b", 64'(f_b), 64'd0);
    check_eq("abort_f_a", 64'(f_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
